// File: rtl/microwave_pkg.sv
// Shared types and constants for the microwave cooking-time countdown.
package microwave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int BCD_W        = 4;
    localparam int SEC_TENS_W   = 3;
    localparam int SEC_TENS_MOD = 6;
    localparam int BCD_MOD      = 10;

    function automatic logic [BCD_W-1:0] sat_bcd(input logic [BCD_W-1:0] v,
                                                 input logic [BCD_W-1:0] lim);
        return (v > lim) ? lim : v;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One modulo-MOD down-counting digit; borrow_out flags a wrap so the next
// digit up decrements in the same cycle.
module bcd_down_digit #(
    parameter int MOD   = 10,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             dec,
    output logic [WIDTH-1:0] q,
    output logic             borrow_out
);

    assign borrow_out = dec && (q == '0);

    always_ff @(posedge clk) begin
        if (reset || clear)
            q <= '0;
        else if (load)
            q <= d;
        else if (dec)
            q <= (q == '0) ? WIDTH'(MOD - 1) : q - WIDTH'(1);
    end

endmodule

// File: rtl/microwave_countdown_timer.sv
// mm:ss BCD cooking-time countdown with load/start/pause/cancel control.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | value loaded or cleared, waiting for start
//   ST_RUN   | decrementing one second per tick
//   ST_PAUSE | countdown suspended, digits held
//   ST_DONE  | reached 00:00, waiting for load or cancel
module microwave_countdown_timer
    import microwave_pkg::*;
#(
    parameter int MIN_TENS_MAX = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  load,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  cancel,
    input  logic [BCD_W-1:0]      min_tens_in,
    input  logic [BCD_W-1:0]      min_ones_in,
    input  logic [SEC_TENS_W-1:0] sec_tens_in,
    input  logic [BCD_W-1:0]      sec_ones_in,
    output logic [BCD_W-1:0]      min_tens,
    output logic [BCD_W-1:0]      min_ones,
    output logic [SEC_TENS_W-1:0] sec_tens,
    output logic [BCD_W-1:0]      sec_ones,
    output logic                  running,
    output logic                  paused,
    output logic                  done
);

    localparam logic [BCD_W-1:0] MT_LIM = BCD_W'(MIN_TENS_MAX);
    localparam logic [BCD_W-1:0] ONES_LIM = BCD_W'(BCD_MOD - 1);
    localparam logic [SEC_TENS_W-1:0] ST_LIM = SEC_TENS_W'(SEC_TENS_MOD - 1);

    state_t state, state_nxt;
    logic   load_acc, tick_acc, done_nxt;
    logic   count_zero, count_one;
    logic   so_borrow, st_borrow, mo_borrow, unused_mt_borrow;

    logic [BCD_W-1:0]      mt_d, mo_d, so_d;
    logic [SEC_TENS_W-1:0] st_d;

    assign mt_d = sat_bcd(min_tens_in, MT_LIM);
    assign mo_d = sat_bcd(min_ones_in, ONES_LIM);
    assign so_d = sat_bcd(sec_ones_in, ONES_LIM);
    assign st_d = (sec_tens_in > ST_LIM) ? ST_LIM : sec_tens_in;

    assign count_zero = (min_tens == '0) && (min_ones == '0) &&
                        (sec_tens == '0) && (sec_ones == '0);
    // 00:01 is the only value whose next tick lands on 00:00
    assign count_one  = (min_tens == '0) && (min_ones == '0) &&
                        (sec_tens == '0) && (sec_ones == BCD_W'(1));

    always_comb begin
        state_nxt = state;
        load_acc  = 1'b0;
        tick_acc  = 1'b0;
        done_nxt  = 1'b0;
        if (cancel) begin
            state_nxt = ST_IDLE;
        end else if (load && state != ST_RUN) begin
            load_acc  = 1'b1;
            state_nxt = ST_IDLE;
        end else if (pause && state == ST_RUN) begin
            state_nxt = ST_PAUSE;
        end else if (start && (state == ST_IDLE || state == ST_PAUSE) && !count_zero) begin
            state_nxt = ST_RUN;
        end else if (tick && state == ST_RUN) begin
            tick_acc = 1'b1;
            if (count_one) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
        end
    end

    assign running = (state == ST_RUN);
    assign paused  = (state == ST_PAUSE);

    bcd_down_digit #(.MOD(BCD_MOD), .WIDTH(BCD_W)) u_sec_ones (
        .clk(clk), .reset(reset), .clear(cancel), .load(load_acc),
        .d(so_d), .dec(tick_acc), .q(sec_ones), .borrow_out(so_borrow)
    );

    bcd_down_digit #(.MOD(SEC_TENS_MOD), .WIDTH(SEC_TENS_W)) u_sec_tens (
        .clk(clk), .reset(reset), .clear(cancel), .load(load_acc),
        .d(st_d), .dec(so_borrow), .q(sec_tens), .borrow_out(st_borrow)
    );

    bcd_down_digit #(.MOD(BCD_MOD), .WIDTH(BCD_W)) u_min_ones (
        .clk(clk), .reset(reset), .clear(cancel), .load(load_acc),
        .d(mo_d), .dec(st_borrow), .q(min_ones), .borrow_out(mo_borrow)
    );

    bcd_down_digit #(.MOD(BCD_MOD), .WIDTH(BCD_W)) u_min_tens (
        .clk(clk), .reset(reset), .clear(cancel), .load(load_acc),
        .d(mt_d), .dec(mo_borrow), .q(min_tens), .borrow_out(unused_mt_borrow)
    );

endmodule

// File: tb/tb_microwave_countdown_timer.sv
// Scoreboard bench: a seconds-based model predicts every cycle's outputs,
// a separate monitor compares them one cycle after each edge.
module tb_microwave_countdown_timer;

    logic       clk = 1'b0;
    logic       reset = 1'b0, tick = 1'b0, load = 1'b0, start = 1'b0;
    logic       pause = 1'b0, cancel = 1'b0;
    logic [3:0] min_tens_in = '0, min_ones_in = '0, sec_ones_in = '0;
    logic [2:0] sec_tens_in = '0;
    logic [3:0] min_tens, min_ones, sec_ones;
    logic [2:0] sec_tens;
    logic       running, paused, done;

    microwave_countdown_timer dut (
        .clk(clk), .reset(reset), .tick(tick), .load(load), .start(start),
        .pause(pause), .cancel(cancel),
        .min_tens_in(min_tens_in), .min_ones_in(min_ones_in),
        .sec_tens_in(sec_tens_in), .sec_ones_in(sec_ones_in),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
        .sec_ones(sec_ones), .running(running), .paused(paused), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int mt, mo, st, so;
        bit run, pau, dn;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0, failed = 0;

    // model: whole seconds remaining plus a mode word (0 idle,1 run,2 pause,3 done)
    int m_secs = 0, m_mode = 0;
    bit m_done = 0;

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic step(input bit rst, input bit ld, input bit st, input bit pa,
                        input bit ca, input bit tk,
                        input int imt, input int imo, input int ist, input int iso);
        exp_t e;
        @(negedge clk);
        reset = rst; load = ld; start = st; pause = pa; cancel = ca; tick = tk;
        min_tens_in = 4'(imt); min_ones_in = 4'(imo);
        sec_tens_in = 3'(ist); sec_ones_in = 4'(iso);
        m_done = 0;
        if (rst) begin
            m_secs = 0; m_mode = 0;
        end else if (ca) begin
            m_secs = 0; m_mode = 0;
        end else if (ld && m_mode != 1) begin
            m_secs = (imin(imt, 9) * 10 + imin(imo, 9)) * 60 + imin(ist, 5) * 10 + imin(iso, 9);
            m_mode = 0;
        end else if (pa && m_mode == 1) begin
            m_mode = 2;
        end else if (st && (m_mode == 0 || m_mode == 2) && m_secs != 0) begin
            m_mode = 1;
        end else if (tk && m_mode == 1) begin
            m_secs = m_secs - 1;
            if (m_secs == 0) begin
                m_mode = 3; m_done = 1;
            end
        end
        e.mt = (m_secs / 60) / 10;
        e.mo = (m_secs / 60) % 10;
        e.st = (m_secs % 60) / 10;
        e.so = m_secs % 10;
        e.run = (m_mode == 1);
        e.pau = (m_mode == 2);
        e.dn  = m_done;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
            idle(1);
        end
    endtask

    task automatic do_load(input int imt, input int imo, input int ist, input int iso);
        step(0, 1, 0, 0, 0, 0, imt, imo, ist, iso);
    endtask

    task automatic do_start();
        step(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (int'(min_tens) != e.mt || int'(min_ones) != e.mo ||
                    int'(sec_tens) != e.st || int'(sec_ones) != e.so ||
                    running != e.run || paused != e.pau || done != e.dn) begin
                    failed++;
                    $display("FAIL outputs t=%0t got %0d%0d:%0d%0d run=%0b pau=%0b done=%0b, expected %0d%0d:%0d%0d run=%0b pau=%0b done=%0b",
                             $time, min_tens, min_ones, sec_tens, sec_ones, running, paused, done,
                             e.mt, e.mo, e.st, e.so, e.run, e.pau, e.dn);
                end
            end
        end
    end

    initial begin : stimulus
        bit prev_tk;
        int waited;
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);

        // 01:05 down through the seconds-tens wrap
        do_load(0, 1, 0, 5);
        do_start();
        ticks(5);
        ticks(1);

        // 00:02 to DONE; done pulses once; further tick/start ignored
        do_load(0, 0, 0, 2);
        do_start();
        ticks(2);
        idle(2);
        ticks(1);
        do_start();
        idle(1);

        // pause together with tick drops the tick
        do_load(0, 0, 3, 1);
        do_start();
        ticks(1);
        step(0, 0, 0, 1, 0, 1, 0, 0, 0, 0);
        ticks(3);
        do_start();
        ticks(1);

        // saturating load, then start at 00:00 is ignored
        do_load(15, 5, 7, 12);
        idle(1);
        do_load(0, 0, 0, 0);
        do_start();
        idle(1);

        // cancel in RUN; load ignored in RUN
        do_load(1, 0, 0, 0);
        do_start();
        step(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        do_load(1, 0, 0, 0);
        do_start();
        step(0, 1, 0, 0, 0, 0, 3, 3, 3, 3);
        ticks(2);
        step(0, 1, 0, 0, 0, 1, 2, 2, 2, 2);
        idle(1);

        // reset mid-RUN together with tick
        step(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        idle(1);

        prev_tk = 0;
        for (int i = 0; i < 3000; i++) begin
            bit r, l, s, p, c, t;
            int a, b, cc, d;
            r = ($urandom_range(0, 199) == 0);
            c = ($urandom_range(0, 99) == 0);
            l = ($urandom_range(0, 19) == 0);
            p = ($urandom_range(0, 29) == 0);
            s = ($urandom_range(0, 7) == 0);
            t = prev_tk ? 1'b0 : 1'($urandom_range(0, 1));
            prev_tk = t;
            if ($urandom_range(0, 2) == 0) begin
                a = $urandom_range(0, 15); b = $urandom_range(0, 15);
                cc = $urandom_range(0, 7); d = $urandom_range(0, 15);
            end else begin
                a = 0; b = 0; cc = $urandom_range(0, 1); d = $urandom_range(0, 12);
            end
            step(r, l, s, p, c, t, a, b, cc, d);
        end
        idle(2);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            failed++;
            $display("FAIL drain got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/microwave_countdown_timer.md
# microwave_countdown_timer

Cooking-time countdown for the microwave controller: holds a BCD mm:ss value and decrements it once per 1 Hz tick while running. The seconds-tens digit is modulo 6 and the seconds/minutes-ones digits are modulo 10, so this block is the count-down counterpart of the up-counting time-entry path. It sits between the keypad/time-entry logic, which loads the value, and the display and magnetron control, which consume the digits, `running` and `done`.

## Interface
- `MIN_TENS_MAX`, default 9: largest accepted minutes-tens digit; larger load values saturate to this.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `tick`  in  1  one-cycle 1 Hz enable pulse from the prescaler.
- `load`  in  1  capture the `*_in` digits.
- `start`  in  1  begin or resume countdown.
- `pause`  in  1  suspend countdown (door open / pause key).
- `cancel`  in  1  abort and clear to 00:00.
- `min_tens_in`  in  4  BCD minutes tens.
- `min_ones_in`  in  4  BCD minutes ones.
- `sec_tens_in`  in  3  seconds tens, 0–5.
- `sec_ones_in`  in  4  BCD seconds ones.
- `min_tens`, `min_ones`, `sec_ones`  out  4  current digits.
- `sec_tens`  out  3  current seconds-tens digit.
- `running`  out  1  high in RUN.
- `paused`  out  1  high in PAUSE.
- `done`  out  1  one-cycle pulse when the count reaches 00:00.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Reset: state IDLE, all digits 0, `running`/`paused`/`done` 0.
- Input priority, highest first: reset > cancel > load > pause > start > tick.
- `cancel`: from any state, go to IDLE and clear the digits to 00:00.
- `load`: accepted in IDLE, PAUSE and DONE; ignored in RUN.
  - Captures the digits and goes to IDLE.
  - Saturation per digit: ones >9 → 9, `sec_tens_in` >5 → 5, `min_tens_in` >`MIN_TENS_MAX` → `MIN_TENS_MAX`.
- `start`: IDLE or PAUSE with a nonzero count → RUN. Ignored when the count is 00:00, in RUN, and in DONE.
- `pause`: RUN → PAUSE. Ignored in all other states.
  - A `tick` in the same cycle as `pause` is discarded.
- RUN, on `tick`: subtract one second with a borrow chain.
  - `sec_ones` 0 → 9 and borrow; else decrement.
  - `sec_tens` on borrow: 0 → 5 and borrow; else decrement.
  - `min_ones` on borrow: 0 → 9 and borrow; else decrement.
  - `min_tens` on borrow: decrement.
  - If the result is 00:00, next state is DONE.
- RUN without `tick`: hold.
- DONE: digits stay at 00:00 until `load` or `cancel`. Ticks are ignored.
- Ticks in IDLE, PAUSE or DONE never change the digits.

## Timing
- All outputs are registered. Digit change and state change appear the cycle after the qualifying input edge; latency is 1.
- `running` and `paused` are decoded directly from the state register.
- `done`: high for exactly the first cycle in DONE, i.e. the same cycle the digits first read 00:00 after a tick. It does not re-fire while the block stays in DONE.
- Underflow is impossible: RUN is never entered at 00:00, and at 00:01 the next tick lands in DONE.
- `reset` or `cancel` during RUN takes effect at the next edge, even if `tick` is high in that cycle.
- `tick` wider than one cycle counts once per high cycle. The bench must drive single-cycle pulses.

## Structure
- Shared package `microwave_pkg` holds:
  - the state enum (IDLE/RUN/PAUSE/DONE);
  - digit width constants (4 for BCD digits, 3 for seconds tens);
  - modulus constants SEC_TENS_MOD = 6 and BCD_MOD = 10.
- Sub-module `bcd_down_digit`, parameterised by MOD and WIDTH, instantiated four times:
  - inputs `clk`, `reset`, `clear`, `load`, `d`, `dec`;
  - outputs `q`, `borrow_out` (combinational: `dec` high while `q` is 0);
  - the minutes-tens instance ignores `borrow_out`.
- The top level contains the FSM, saturation logic, zero detect and the `done` pulse.

## Test plan
- Reset, then `load` 01:05 and `start`, then 5 ticks → digits read 01:00. The 6th tick → 00:59, confirming the seconds-tens wrap 0→5 with borrow.
- `load` 00:02, `start`, 2 ticks → DONE; `done` high exactly one cycle; digits 00:00; `running` 0. A further tick and a `start` → no change.
- RUN at 00:30: `pause` together with `tick` → `paused` 1 and digits stay 00:30. 3 ticks → still 00:30. `start` plus 1 tick → 00:29.
- `load` with `sec_tens_in`=7, `sec_ones_in`=12, `min_tens_in`=15 → digits read 95:59 with default `MIN_TENS_MAX`. `start` with 00:00 loaded → state stays IDLE.
- RUN at 10:00: `cancel` → IDLE, 00:00 the next cycle. `load` asserted during RUN → ignored, countdown continues.
- `reset` asserted mid-RUN in the same cycle as a `tick` → all digits 0, state IDLE, `done` 0 at the next edge.
